// File: rtl/serial_pkg.sv
// Shared definitions for the serial byte transmitter and its matching receiver.
//   tx_state_e : transmitter frame states
//   DATA_BITS  : payload bits per frame
//   LINE_IDLE  : line level when no frame is on the wire (also the stop level)
//   START_LVL  : line level of the start bit
//   odd_parity : parity bit that makes the total count of ones odd
package serial_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_e;

    localparam int   DATA_BITS = 8;
    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_LVL = 1'b0;

    function automatic logic odd_parity(input logic [DATA_BITS-1:0] b);
        return ~^b;
    endfunction

endpackage

// File: rtl/serial_bit_timer.sv
// Bit-period counter for the serial transmitter.
//   clk       : clock, all logic on posedge
//   reset     : synchronous, active-high
//   clear     : force the count back to zero
//   enable    : advance the count this cycle
//   last_tick : high in the final cycle of the current bit period
module serial_bit_timer #(
    parameter int CLKS_PER_BIT = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic last_tick
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // The count wraps at LAST, so it never exceeds CLKS_PER_BIT-1.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    assign last_tick = enable && (cnt_q == LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/serial_byte_tx.sv
// Byte-to-serial transmitter: one byte per valid/ready handshake becomes one
// frame on the line (start 0, 8 data bits LSB first, optional odd parity,
// STOP_BITS stop 1s). Back-to-back bytes are sent with no idle gap.
//   clk      : clock, all logic on posedge
//   reset    : synchronous, active-high; aborts any frame in flight
//   in_valid : in_data holds a byte to send
//   in_data  : byte to send, sampled only on the handshake edge
//   in_ready : a byte can be accepted this cycle
//   out      : registered serial line, idle high
//   busy     : a frame is in progress
//
// state  | meaning
// IDLE   | line idle high, ready for a byte
// START  | start bit (low) for one bit period
// DATA   | eight data bits, LSB first, from the shift register
// PARITY | odd parity of the byte (only when PARITY_EN)
// STOP   | STOP_BITS bit periods high; last cycle may accept the next byte
module serial_byte_tx
    import serial_pkg::*;
#(
    parameter int CLKS_PER_BIT = 1,
    parameter int PARITY_EN    = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic       out,
    output logic       busy
);

    localparam logic [2:0] IDX_LAST  = 3'(DATA_BITS - 1);
    localparam logic       STOP_LAST = 1'(STOP_BITS - 1);

    tx_state_e            state_q, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_q, par_d;
    logic [2:0]           bit_idx_q, bit_idx_d;
    logic                 stop_idx_q, stop_idx_d;
    logic                 out_q, out_d;

    logic last_tick;
    logic last_stop;
    logic hs;

    // The counter sits at zero in IDLE, so a new frame always starts a fresh
    // bit period; from STOP into START it wraps to zero on its own.
    serial_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_timer (
        .clk       (clk),
        .reset     (reset),
        .clear     (state_q == IDLE),
        .enable    (state_q != IDLE),
        .last_tick (last_tick)
    );

    assign last_stop = (state_q == STOP) && last_tick && (stop_idx_q == STOP_LAST);
    assign in_ready  = (state_q == IDLE) || last_stop;
    assign hs        = in_valid && in_ready;

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        par_d      = par_q;
        bit_idx_d  = bit_idx_q;
        stop_idx_d = stop_idx_q;

        case (state_q)
            IDLE: begin
                if (hs) begin
                    state_d = START;
                    shift_d = in_data;
                    par_d   = odd_parity(in_data);
                end
            end
            START: begin
                if (last_tick) begin
                    state_d   = DATA;
                    bit_idx_d = '0;
                end
            end
            DATA: begin
                if (last_tick) begin
                    shift_d = shift_q >> 1;
                    if (bit_idx_q == IDX_LAST) begin
                        state_d    = (PARITY_EN != 0) ? PARITY : STOP;
                        stop_idx_d = 1'b0;
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (last_tick) begin
                    state_d    = STOP;
                    stop_idx_d = 1'b0;
                end
            end
            STOP: begin
                if (last_tick) begin
                    if (stop_idx_q == STOP_LAST) begin
                        if (hs) begin
                            state_d = START;
                            shift_d = in_data;
                            par_d   = odd_parity(in_data);
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        stop_idx_d = stop_idx_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Line level follows the state being entered, so out is registered
        // and a handshake shows the start bit one cycle later.
        case (state_d)
            START:   out_d = START_LVL;
            DATA:    out_d = shift_d[0];
            PARITY:  out_d = par_d;
            default: out_d = LINE_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            par_q      <= 1'b0;
            bit_idx_q  <= '0;
            stop_idx_q <= 1'b0;
            out_q      <= LINE_IDLE;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            par_q      <= par_d;
            bit_idx_q  <= bit_idx_d;
            stop_idx_q <= stop_idx_d;
            out_q      <= out_d;
        end
    end

    assign out  = out_q;
    assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_serial_byte_tx.sv
// Bench for serial_byte_tx. Three instances cover the default configuration,
// odd parity, and a 4-clock bit with two stop bits. A frame-level reference
// model predicts out/busy/in_ready every cycle for every instance.
module tb_serial_byte_tx;

    logic       clk;
    logic       rst   [3];
    logic       vld   [3];
    logic [7:0] dat   [3];
    logic       rdy_w [3];
    logic       out_w [3];
    logic       busy_w[3];

    int   nvec = 0;
    int   errs = 0;
    logic chk_en = 1'b0;
    logic cap [0:99];

    serial_byte_tx #(.CLKS_PER_BIT(1), .PARITY_EN(0), .STOP_BITS(1)) u0 (
        .clk(clk), .reset(rst[0]), .in_valid(vld[0]), .in_data(dat[0]),
        .in_ready(rdy_w[0]), .out(out_w[0]), .busy(busy_w[0]));
    serial_byte_tx #(.CLKS_PER_BIT(1), .PARITY_EN(1), .STOP_BITS(1)) u1 (
        .clk(clk), .reset(rst[1]), .in_valid(vld[1]), .in_data(dat[1]),
        .in_ready(rdy_w[1]), .out(out_w[1]), .busy(busy_w[1]));
    serial_byte_tx #(.CLKS_PER_BIT(4), .PARITY_EN(0), .STOP_BITS(2)) u2 (
        .clk(clk), .reset(rst[2]), .in_valid(vld[2]), .in_data(dat[2]),
        .in_ready(rdy_w[2]), .out(out_w[2]), .busy(busy_w[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int cpb_of(input int k);
        return (k == 2) ? 4 : 1;
    endfunction
    function automatic int par_of(input int k);
        return (k == 1) ? 1 : 0;
    endfunction
    function automatic int stb_of(input int k);
        return (k == 2) ? 2 : 1;
    endfunction
    function automatic int len_of(input int k);
        return (10 + par_of(k) + stb_of(k) - 1) * cpb_of(k);
    endfunction

    // Line bits of one frame, index 0 = start bit; unused upper bits are stop level.
    function automatic logic [11:0] build(input int k, input logic [7:0] d);
        logic [11:0] f;
        f = '1;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) f[1+i] = d[i];
        if (par_of(k) != 0) f[9] = ~^d;
        return f;
    endfunction

    // Reference model: position within the current frame (-1 = idle).
    int          m_pos  [3] = '{-1, -1, -1};
    logic [11:0] m_frame[3];

    function automatic logic m_ready(input int k);
        return (m_pos[k] < 0) || (m_pos[k] == len_of(k) - 1);
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (rst[k]) begin
                m_pos[k] <= -1;
            end else if (m_ready(k) && vld[k]) begin
                m_frame[k] <= build(k, dat[k]);
                m_pos[k]   <= 0;
            end else if (m_pos[k] >= 0 && m_pos[k] < len_of(k) - 1) begin
                m_pos[k] <= m_pos[k] + 1;
            end else begin
                m_pos[k] <= -1;
            end
        end
    end

    task automatic check(input string nm, input int k, input logic act, input logic exp);
        nvec++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s inst%0d t=%0t got %0b want %0b", nm, k, $time, act, exp);
        end
    endtask

    task automatic check_int(input string nm, input int k, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s inst%0d t=%0t got %0d want %0d", nm, k, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 3; k++) begin
                check("model_out",   k, out_w[k],
                      (m_pos[k] < 0) ? 1'b1 : m_frame[k][m_pos[k] / cpb_of(k)]);
                check("model_busy",  k, busy_w[k], (m_pos[k] >= 0));
                check("model_ready", k, rdy_w[k],  m_ready(k));
            end
        end
    end

    task automatic wait_ready(input int k);
        int w;
        w = 0;
        while (!rdy_w[k] && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (!rdy_w[k]) begin
            nvec++;
            errs++;
            $display("FAIL ready_timeout inst%0d got 0 want 1", k);
        end
    endtask

    // Send one byte with a one-cycle valid, then capture the line while busy.
    task automatic send_capture(input int k, input logic [7:0] d, output int n);
        dat[k] = d;
        vld[k] = 1'b1;
        wait_ready(k);
        @(negedge clk);
        vld[k] = 1'b0;
        n = 0;
        while (busy_w[k] && n < 100) begin
            cap[n] = out_w[k];
            n++;
            @(negedge clk);
        end
    endtask

    typedef struct {
        int         k;
        logic [7:0] d;
        int         cycles;
        int         bidx;
        logic       bval;
    } vec_t;

    vec_t tbl[8];

    initial begin
        int          n;
        int          pulses;
        logic        saw;
        logic [11:0] f;

        for (int k = 0; k < 3; k++) begin
            rst[k] = 1'b1;
            vld[k] = 1'b0;
            dat[k] = 8'h00;
        end
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) rst[k] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check("reset_out",   k, out_w[k],  1'b1);
            check("reset_busy",  k, busy_w[k], 1'b0);
            check("reset_ready", k, rdy_w[k],  1'b1);
        end
        chk_en = 1'b1;

        tbl[0] = '{k: 0, d: 8'hA5, cycles: 10, bidx: 3, bval: 1'b1};
        tbl[1] = '{k: 0, d: 8'hA5, cycles: 10, bidx: 2, bval: 1'b0};
        tbl[2] = '{k: 1, d: 8'h07, cycles: 11, bidx: 9, bval: 1'b0};
        tbl[3] = '{k: 1, d: 8'h03, cycles: 11, bidx: 9, bval: 1'b1};
        tbl[4] = '{k: 1, d: 8'hFF, cycles: 11, bidx: 9, bval: 1'b1};
        tbl[5] = '{k: 2, d: 8'h81, cycles: 44, bidx: 8, bval: 1'b1};
        tbl[6] = '{k: 2, d: 8'h81, cycles: 44, bidx: 2, bval: 1'b0};
        tbl[7] = '{k: 0, d: 8'h3C, cycles: 10, bidx: 3, bval: 1'b1};

        for (int i = 0; i < 8; i++) begin
            send_capture(tbl[i].k, tbl[i].d, n);
            check_int("tbl_len", tbl[i].k, n, tbl[i].cycles);
            check("tbl_bit", tbl[i].k, cap[tbl[i].bidx * cpb_of(tbl[i].k)], tbl[i].bval);
            if (tbl[i].k == 2) begin
                check("stop_hold", 2, cap[36], 1'b1);
                check("stop_hold", 2, cap[43], 1'b1);
            end
            repeat (2) @(negedge clk);
        end

        // Back-to-back 0x00 then 0xFF with valid held high.
        dat[0] = 8'h00;
        vld[0] = 1'b1;
        wait_ready(0);
        @(negedge clk);
        dat[0] = 8'hFF;
        n = 0;
        pulses = 0;
        saw = 1'b0;
        while (busy_w[0] && n < 100) begin
            if (saw) vld[0] = 1'b0;
            if (rdy_w[0]) begin
                pulses++;
                saw = 1'b1;
            end
            cap[n] = out_w[0];
            n++;
            @(negedge clk);
        end
        vld[0] = 1'b0;
        check_int("b2b_len", 0, n, 20);
        check_int("b2b_ready_pulses", 0, pulses, 2);
        for (int j = 0; j < 20; j++) begin
            f = build(0, (j < 10) ? 8'h00 : 8'hFF);
            check("b2b_line", 0, cap[j], f[j % 10]);
        end
        repeat (2) @(negedge clk);

        // Reset during data bit 3 of 0x55, then a clean 0x3C frame.
        dat[0] = 8'h55;
        vld[0] = 1'b1;
        wait_ready(0);
        @(negedge clk);
        vld[0] = 1'b0;
        repeat (4) @(negedge clk);
        rst[0] = 1'b1;
        @(negedge clk);
        rst[0] = 1'b0;
        check("abort_out",   0, out_w[0],  1'b1);
        check("abort_busy",  0, busy_w[0], 1'b0);
        check("abort_ready", 0, rdy_w[0],  1'b1);
        send_capture(0, 8'h3C, n);
        check_int("after_abort_len", 0, n, 10);
        f = build(0, 8'h3C);
        for (int j = 0; j < 10; j++) check("after_abort_line", 0, cap[j], f[j]);
        repeat (2) @(negedge clk);

        // Valid pulse with new data while busy must be ignored.
        dat[0] = 8'h12;
        vld[0] = 1'b1;
        wait_ready(0);
        @(negedge clk);
        vld[0] = 1'b0;
        n = 0;
        while (busy_w[0] && n < 100) begin
            if (n == 3) begin
                dat[0] = 8'hFF;
                vld[0] = 1'b1;
                check("ignore_ready", 0, rdy_w[0], 1'b0);
            end else begin
                vld[0] = 1'b0;
            end
            cap[n] = out_w[0];
            n++;
            @(negedge clk);
        end
        vld[0] = 1'b0;
        check_int("ignore_len", 0, n, 10);
        f = build(0, 8'h12);
        for (int j = 0; j < 10; j++) check("ignore_line", 0, cap[j], f[j]);
        @(negedge clk);
        check("ignore_no_extra", 0, busy_w[0], 1'b0);

        // Randomized traffic, including occasional resets, on each instance in turn.
        for (int c = 0; c < 3000; c++) begin
            int ks;
            ks = (c / 500) % 3;
            for (int k = 0; k < 3; k++) begin
                if (k == ks) begin
                    vld[k] = ($urandom_range(0, 3) != 0);
                    dat[k] = 8'($urandom);
                    rst[k] = ($urandom_range(0, 299) == 0);
                end else begin
                    vld[k] = 1'b0;
                    rst[k] = 1'b0;
                end
            end
            @(negedge clk);
        end
        for (int k = 0; k < 3; k++) begin
            vld[k] = 1'b0;
            rst[k] = 1'b0;
        end
        repeat (60) @(negedge clk);
        for (int k = 0; k < 3; k++) check("final_idle", k, busy_w[k], 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, errs);
        $finish;
    end

endmodule
